// File: rtl/pc_bit_streamer.sv
// Bit-serial RAM-to-UART stream engine: packs single-bit RAM samples into
// DATA_W-bit words, launches them on a UART tx handshake, optionally awaits a reply.
module pc_bit_streamer #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 8,
  parameter int NUM_WORDS   = 98,
  parameter int LSB_FIRST   = 1,
  parameter int GAP_CYCLES  = 0,
  parameter int EXPECT_RESP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_q,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_rdy,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        result,
  output logic              result_valid
);

  localparam int WC_W  = $clog2(NUM_WORDS + 1);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int BC_W  = $clog2(DATA_W + 1);

  localparam logic [WC_W-1:0]   WORDS_LAST  = WC_W'(NUM_WORDS - 1);
  localparam logic [WC_W-1:0]   WORDS_TOTAL = WC_W'(NUM_WORDS);
  localparam logic [GAP_W-1:0]  GAP_LAST    = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [BC_W-1:0]   BIT_LAST    = BC_W'(DATA_W);
  localparam logic [DATA_W-1:0] SEL_LSB     = DATA_W'(1);
  localparam logic [DATA_W-1:0] SEL_MSB     = SEL_LSB << (DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_WAIT_TX,
    S_GAP,
    S_WAIT_RESP,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0] pack_q, pack_d;
  logic              tx_first_q, tx_first_d;
  logic [7:0]        result_q, result_d;

  logic [BC_W-1:0]   fetch_idx;
  logic [DATA_W-1:0] bit_sel;
  logic              fetch_rd;

  function automatic state_e after_word(input logic more_words);
    if (more_words) return S_FETCH;
    if (EXPECT_RESP != 0) return S_WAIT_RESP;
    return S_DONE;
  endfunction

  // Sample arriving in FETCH cycle i belongs to fetch index i-1 (one-cycle RAM latency).
  assign fetch_idx = bit_cnt_q - BC_W'(1);
  assign bit_sel   = (LSB_FIRST != 0) ? (SEL_LSB << fetch_idx) : (SEL_MSB >> fetch_idx);
  assign fetch_rd  = (state_q == S_FETCH) && (bit_cnt_q != BIT_LAST);

  assign mem_addr = fetch_rd ? addr_q + ADDR_W'(bit_cnt_q) : '0;
  assign tx_data  = pack_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    addr_d       = addr_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    pack_d       = pack_q;
    tx_first_d   = tx_first_q;
    result_d     = result_q;
    tx_start     = 1'b0;
    result_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d     = base_addr;
          word_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = S_FETCH;
        end
      end

      S_FETCH: begin
        if (bit_cnt_q != '0) begin
          pack_d = mem_q ? (pack_q | bit_sel) : (pack_q & ~bit_sel);
        end
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          addr_d    = addr_q + ADDR_W'(DATA_W);
          state_d   = S_SEND;
        end else begin
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
      end

      // Launch is combinational on tx_rdy so the word leaves in the cycle the UART is free.
      S_SEND: begin
        if (tx_rdy) begin
          tx_start   = 1'b1;
          tx_first_d = 1'b1;
          state_d    = S_WAIT_TX;
        end
      end

      S_WAIT_TX: begin
        if (tx_first_q) begin
          tx_first_d = 1'b0;
        end else if (tx_rdy) begin
          word_cnt_d = word_cnt_q + WC_W'(1);
          if (GAP_CYCLES > 0) begin
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end else begin
            state_d = after_word(word_cnt_q != WORDS_LAST);
          end
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = after_word(word_cnt_q != WORDS_TOTAL);
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      S_WAIT_RESP: begin
        if (rx_rdy) begin
          result_d     = rx_data;
          result_valid = 1'b1;
          state_d      = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      gap_cnt_q  <= '0;
      pack_q     <= '0;
      tx_first_q <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      pack_q     <= pack_d;
      tx_first_q <= tx_first_d;
      result_q   <= result_d;
    end
  end

endmodule
